imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, XLEN-parametrised immediate generator for the decode stage. It accepts an instruction word and immediate-type select through a valid/ready handshake and returns the sign- or zero-extended immediate one cycle later, along with a caller tag. A 2-entry skid buffer gives full throughput under downstream backpressure, and a flush input discards in-flight work on redirect. It replaces the combinational immediate generator wherever decode is split into a separate pipeline stage.

## Interface
Parameters:
- XLEN, 32, output immediate width; legal values are 32 and 64.
- TAG_W, 5, width of the opaque tag passed through with each request (e.g. rd or ROB index).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- io_flush  in  1  drops all buffered entries at the next edge.
- io_in_valid  in  1  request valid.
- io_in_ready  out  1  request accepted when valid && ready.
- io_in_bits_inst  in  32  instruction word.
- io_in_bits_sel  in  3  immediate type: 0=X (I-imm with bit0 cleared, JALR target), 1=I, 2=S, 3=U, 4=J, 5=B, 6=Z (CSR zimm), 7=reserved.
- io_in_bits_tag  in  TAG_W  passthrough tag.
- io_out_valid  out  1  result valid.
- io_out_ready  in  1  consumer accepts when valid && ready.
- io_out_bits_imm  out  XLEN  generated immediate.
- io_out_bits_tag  out  TAG_W  tag of the request that produced the result.
- io_out_bits_err  out  1  reserved-select flag (present only with IMM_GEN_PIPE_ERR_EN).

## Operation
- Immediate construction uses RV32/RV64 base encodings. I, S, B, U and J are sign-extended from inst[31] to XLEN.
  - I = inst[31:20].
  - S = {inst[31:25], inst[11:7]}.
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U = {inst[31:12], 12'h0}; on XLEN=64, bits 63:32 copy inst[31].
  - J = {inst[31], inst[19:12], inst[20], inst[30:25], inst[24:21], 0}.
  - Z = zero-extended inst[19:15].
  - X = I-imm with bit 0 forced to 0.
- Sel 7 with no macro: result is identical to sel 0.
- Storage is two entries, each holding {imm, tag, err}:
  - Output register (OUT) drives io_out_*.
  - Skid register (SKID) holds one extra entry.
- The immediate is computed combinationally from the input and registered, so there is one register stage on the data path.
- State is encoded by {out_v, skid_v}: EMPTY (0,0), ONE (1,0), FULL (1,1). (0,1) is illegal.
- Transitions (acc = in_valid && in_ready, deq = out_valid && out_ready):
  - EMPTY: acc moves to ONE, with OUT loaded.
  - ONE: acc && deq stays ONE, with OUT reloaded. acc alone moves to FULL, with SKID loaded. deq alone moves to EMPTY.
  - FULL: deq moves to ONE, with OUT taking SKID. No accept is possible in FULL.
- io_in_ready = !skid_v && !reset. It is a register-derived signal with no combinational path from io_out_ready.
- Entries leave in acceptance order.
- Flush: at the next edge out_v and skid_v are cleared. A request presented in the flush cycle is not accepted: io_in_ready is low while io_flush=1. Flush has priority over dequeue and over acceptance.

## Timing
- Reset values: io_out_valid=0, io_in_ready=0 while reset is high and 1 in the first cycle after reset deasserts. io_out_bits_imm, tag and err are 0 after reset.
- Latency: a request accepted at edge N is visible on io_out_* in cycle N+1.
- Throughput: 1 per cycle while io_out_ready=1.
- After one cycle of io_out_ready=0 from ONE, the block absorbs one more request and then deasserts io_in_ready.
- io_out_bits_* hold stable while io_out_valid=1 and io_out_ready=0.
- Reset asserted mid-stream: all entries are discarded at that edge, with the same result as flush.
- Simultaneous io_flush and reset: reset values apply.

## Configuration
- IMM_GEN_PIPE_ERR_EN defined:
  - io_out_bits_err exists and is 1 for sel=7, else 0.
  - For sel=7, io_out_bits_imm is 0.
- Undefined: the port and its storage bit are absent, and sel=7 behaves as sel=0.

## Test plan
- XLEN=32, I-type: inst 0xFFF00093, sel=1, tag=3 -> next cycle imm=0xFFFFFFFF, tag=3.
- XLEN=64, U-type: inst 0x80000037, sel=3 -> imm=0xFFFFFFFF80000000. Also inst 0x12345037 -> 0x0000000012345000.
- B/Z/X types:
  - inst 0xFE000EE3, sel=5 -> imm=0xFFFFFFFC.
  - inst 0x000FD073, sel=6 -> imm=0x1F.
  - inst 0x00300067, sel=0 -> imm=0x2.
- Backpressure: stream tags 1..6 with io_out_ready low for cycles 2–4.
  - io_in_ready drops after the second buffered entry.
  - Output order is 1..6, with no loss or duplication.
  - io_out_bits stay stable while stalled.
- Flush in FULL: assert io_flush for 1 cycle with valid input present -> next cycle io_out_valid=0, io_in_ready=1, and the flushed-cycle input never appears on the output.
- With IMM_GEN_PIPE_ERR_EN: sel=7, inst 0xFFFFFFFF -> err=1, imm=0. Without the macro, the same stimulus -> imm=0xFFFFFFFE.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with 2-entry skid buffer (optional IMM_GEN_PIPE_ERR_EN)
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_flush,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [31:0]      io_in_bits_inst,
  input  logic [2:0]       io_in_bits_sel,
  input  logic [TAG_W-1:0] io_in_bits_tag,
  output logic             io_out_valid,
  input  logic             io_out_ready,
`ifdef IMM_GEN_PIPE_ERR_EN
  output logic             io_out_bits_err,
`endif
  output logic [XLEN-1:0]  io_out_bits_imm,
  output logic [TAG_W-1:0] io_out_bits_tag
);

  // Encoding is {out_v, skid_v}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      inst;
  logic [31:0]      i_imm, x_imm, s_imm, b_imm, u_imm, j_imm, z_imm;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  new_imm;
  logic             acc, deq;
  logic             load_out_new, load_out_skid, load_skid;
  logic [XLEN-1:0]  out_imm_q, skid_imm_q;
  logic [TAG_W-1:0] out_tag_q, skid_tag_q;
  logic             unused_inst_bits;
`ifdef IMM_GEN_PIPE_ERR_EN
  logic             new_err;
  logic             out_err_q, skid_err_q;
`endif

  assign inst             = io_in_bits_inst;
  assign unused_inst_bits = ^inst[6:0];

  // Every format is first built as a 32-bit value already sign-extended to bit 31;
  // Z has bit 31 clear, so one final sign extension to XLEN serves all types.
  assign i_imm = {{20{inst[31]}}, inst[31:20]};
  assign x_imm = {i_imm[31:1], 1'b0};
  assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign u_imm = {inst[31:12], 12'h000};
  assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:25], inst[24:21], 1'b0};
  assign z_imm = {27'd0, inst[19:15]};

  // Select the immediate format for the incoming request.
  always_comb begin
    imm32 = x_imm;
`ifdef IMM_GEN_PIPE_ERR_EN
    new_err = 1'b0;
`endif
    case (io_in_bits_sel)
      3'd1: imm32 = i_imm;
      3'd2: imm32 = s_imm;
      3'd3: imm32 = u_imm;
      3'd4: imm32 = j_imm;
      3'd5: imm32 = b_imm;
      3'd6: imm32 = z_imm;
      3'd7: begin
`ifdef IMM_GEN_PIPE_ERR_EN
        imm32   = 32'd0;
        new_err = 1'b1;
`else
        imm32 = x_imm;
`endif
      end
      default: imm32 = x_imm;
    endcase
  end

  assign new_imm = XLEN'(signed'(imm32));

  // Ready depends only on registered occupancy plus reset/flush, never on io_out_ready.
  assign io_in_ready  = !state_q[0] && !reset && !io_flush;
  assign io_out_valid = state_q[1];
  assign acc          = io_in_valid && io_in_ready;
  assign deq          = io_out_valid && io_out_ready;

  // Occupancy state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy and which data register loads; flush beats dequeue and accept.
  always_comb begin
    state_d       = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (io_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d      = ONE;
            load_out_new = 1'b1;
          end
        end
        ONE: begin
          if (acc && deq) begin
            load_out_new = 1'b1;
          end else if (acc) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (deq) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (deq) begin
            state_d       = ONE;
            load_out_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output and skid payload registers; contents hold unless explicitly loaded.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_imm_q  <= '0;
      out_tag_q  <= '0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
`ifdef IMM_GEN_PIPE_ERR_EN
      out_err_q  <= 1'b0;
      skid_err_q <= 1'b0;
`endif
    end else begin
      if (load_out_new) begin
        out_imm_q <= new_imm;
        out_tag_q <= io_in_bits_tag;
`ifdef IMM_GEN_PIPE_ERR_EN
        out_err_q <= new_err;
`endif
      end else if (load_out_skid) begin
        out_imm_q <= skid_imm_q;
        out_tag_q <= skid_tag_q;
`ifdef IMM_GEN_PIPE_ERR_EN
        out_err_q <= skid_err_q;
`endif
      end
      if (load_skid) begin
        skid_imm_q <= new_imm;
        skid_tag_q <= io_in_bits_tag;
`ifdef IMM_GEN_PIPE_ERR_EN
        skid_err_q <= new_err;
`endif
      end
    end
  end

  assign io_out_bits_imm = out_imm_q;
  assign io_out_bits_tag = out_tag_q;
`ifdef IMM_GEN_PIPE_ERR_EN
  assign io_out_bits_err = out_err_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;
  localparam int TAG_W = 5;

  typedef struct {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } ent_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             io_flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      inst = '0;
  logic [2:0]       sel = '0;
  logic [TAG_W-1:0] tag = '0;
  logic             rdy32, rdy64, ov32, ov64;
  logic [31:0]      imm32;
  logic [63:0]      imm64;
  logic [TAG_W-1:0] t32, t64;
`ifdef IMM_GEN_PIPE_ERR_EN
  logic             e32, e64;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_in_valid(in_valid), .io_in_ready(rdy32),
    .io_in_bits_inst(inst), .io_in_bits_sel(sel), .io_in_bits_tag(tag),
    .io_out_valid(ov32), .io_out_ready(out_ready),
`ifdef IMM_GEN_PIPE_ERR_EN
    .io_out_bits_err(e32),
`endif
    .io_out_bits_imm(imm32), .io_out_bits_tag(t32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_in_valid(in_valid), .io_in_ready(rdy64),
    .io_in_bits_inst(inst), .io_in_bits_sel(sel), .io_in_bits_tag(tag),
    .io_out_valid(ov64), .io_out_ready(out_ready),
`ifdef IMM_GEN_PIPE_ERR_EN
    .io_out_bits_err(e64),
`endif
    .io_out_bits_imm(imm64), .io_out_bits_tag(t64)
  );

  // Reference: immediate value as signed arithmetic over the encoded fields.
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s);
    longint sgn;
    longint iv;
    longint v;
    sgn = i[31] ? -64'sd1 : 64'sd0;
    iv  = sgn * 2048 + longint'(i[30:20]);
    case (s)
      3'd1: v = iv;
      3'd2: v = sgn * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:7]);
      3'd3: v = sgn * (longint'(1) << 31) + longint'(i[30:12]) * 4096;
      3'd4: v = sgn * (longint'(1) << 20) + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
                + longint'(i[30:25]) * 32 + longint'(i[24:21]) * 2;
      3'd5: v = sgn * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      3'd6: v = longint'(i[19:15]);
      3'd7: begin
`ifdef IMM_GEN_PIPE_ERR_EN
        v = 0;
`else
        v = iv & ~longint'(1);
`endif
      end
      default: v = iv & ~longint'(1);
    endcase
    return v;
  endfunction

  function automatic logic ref_err(input logic [2:0] s);
`ifdef IMM_GEN_PIPE_ERR_EN
    return s == 3'd7;
`else
    return (s == 3'd7) && 1'b0;
`endif
  endfunction

  task automatic clear_pipe();
    @(negedge clock);
    in_valid = 1'b0;
    io_flush = 1'b1;
    @(negedge clock);
    io_flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    inst = 32'hFFF00093;
    sel = 3'd1;
    tag = 5'd7;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (ov32 !== 1'b0 || ov64 !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b/%b want 0", ov32, ov64);
    end
    checks++;
    if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready: got %b/%b want 0", rdy32, rdy64);
    end
    checks++;
    if (imm32 !== 32'd0 || imm64 !== 64'd0 || t32 !== '0 || t64 !== '0) begin
      failures++;
      $display("FAIL reset_data: imm %h/%h tag %h/%h want 0", imm32, imm64, t32, t64);
    end
`ifdef IMM_GEN_PIPE_ERR_EN
    checks++;
    if (e32 !== 1'b0 || e64 !== 1'b0) begin
      failures++;
      $display("FAIL reset_err: got %b/%b want 0", e32, e64);
    end
`endif
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_in_ready: got %b/%b want 1", rdy32, rdy64);
    end
  endtask

  task automatic test_vectors();
    logic [63:0] exp;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      case (k)
        0: begin inst = 32'hFFF00093; sel = 3'd1; exp = 64'hFFFFFFFFFFFFFFFF; end
        1: begin inst = 32'h80000037; sel = 3'd3; exp = 64'hFFFFFFFF80000000; end
        2: begin inst = 32'h12345037; sel = 3'd3; exp = 64'h0000000012345000; end
        3: begin inst = 32'hFE000EE3; sel = 3'd5; exp = 64'hFFFFFFFFFFFFFFFC; end
        4: begin inst = 32'h000FD073; sel = 3'd6; exp = 64'h000000000000001F; end
        5: begin inst = 32'h00300067; sel = 3'd0; exp = 64'h0000000000000002; end
        6: begin inst = 32'hFE112E23; sel = 3'd2; exp = 64'hFFFFFFFFFFFFFFFC; end
        default: begin inst = 32'hFF9FF06F; sel = 3'd4; exp = 64'hFFFFFFFFFFFFFFF8; end
      endcase
      tag = TAG_W'(k + 3);
      in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      checks++;
      if (ov32 !== 1'b1 || ov64 !== 1'b1) begin
        failures++;
        $display("FAIL vec%0d_valid: got %b/%b want 1", k, ov32, ov64);
      end
      checks++;
      if (imm64 !== exp || imm32 !== exp[31:0] || t32 !== TAG_W'(k + 3) || t64 !== TAG_W'(k + 3)) begin
        failures++;
        $display("FAIL vec%0d_imm: imm %h/%h tag %0d/%0d want %h tag %0d", k, imm32, imm64, t32, t64, exp, k + 3);
      end
`ifdef IMM_GEN_PIPE_ERR_EN
      checks++;
      if (e32 !== 1'b0 || e64 !== 1'b0) begin
        failures++;
        $display("FAIL vec%0d_err: got %b/%b want 0", k, e32, e64);
      end
`endif
    end
    @(negedge clock);
  endtask

  task automatic test_reserved();
    logic [63:0] exp;
    logic        exp_e;
`ifdef IMM_GEN_PIPE_ERR_EN
    exp = 64'd0;
    exp_e = 1'b1;
`else
    exp = 64'hFFFFFFFFFFFFFFFE;
    exp_e = 1'b0;
`endif
    out_ready = 1'b1;
    @(negedge clock);
    inst = 32'hFFFFFFFF;
    sel = 3'd7;
    tag = 5'd9;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    checks++;
    if (ov64 !== 1'b1 || imm64 !== exp || imm32 !== exp[31:0] || t64 !== 5'd9) begin
      failures++;
      $display("FAIL reserved_sel: valid %b imm %h/%h tag %0d want imm %h tag 9", ov64, imm32, imm64, t64, exp);
    end
`ifdef IMM_GEN_PIPE_ERR_EN
    checks++;
    if (e32 !== exp_e || e64 !== exp_e) begin
      failures++;
      $display("FAIL reserved_err: got %b/%b want %b", e32, e64, exp_e);
    end
`else
    checks++;
    if (ref_err(sel) !== exp_e) begin
      failures++;
      $display("FAIL reserved_model_err: got %b want %b", ref_err(sel), exp_e);
    end
`endif
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    logic [31:0]      insts [7];
    logic [2:0]       sels [7];
    int               sent = 0;
    int               recv = 0;
    int               held;
    int               low_seen = 0;
    logic             stalled = 1'b0;
    logic             exp_rdy;
    logic [63:0]      hold_imm = '0;
    logic [TAG_W-1:0] hold_tag = '0;
    logic [63:0]      exp;
    for (int i = 0; i < 7; i++) begin
      insts[i] = $urandom;
      sels[i] = 3'($urandom_range(0, 6));
    end
    for (int c = 0; c < 40 && recv < 6; c++) begin
      @(negedge clock);
      held = sent - recv;
      in_valid = (sent < 6);
      if (sent < 6) begin
        inst = insts[sent + 1];
        sel = sels[sent + 1];
        tag = TAG_W'(sent + 1);
      end
      out_ready = !(c >= 2 && c <= 4);
      #1;
      exp_rdy = (held < 2);
      checks++;
      if (rdy32 !== exp_rdy || rdy64 !== exp_rdy) begin
        failures++;
        $display("FAIL bp_in_ready c%0d: got %b/%b want %b", c, rdy32, rdy64, exp_rdy);
      end
      checks++;
      if (ov32 !== (held > 0) || ov64 !== (held > 0)) begin
        failures++;
        $display("FAIL bp_out_valid c%0d: got %b/%b want %b", c, ov32, ov64, held > 0);
      end
      if (held > 0) begin
        exp = ref_imm(insts[recv + 1], sels[recv + 1]);
        checks++;
        if (t32 !== TAG_W'(recv + 1) || t64 !== TAG_W'(recv + 1) || imm64 !== exp || imm32 !== exp[31:0]) begin
          failures++;
          $display("FAIL bp_order c%0d: tag %0d imm %h want tag %0d imm %h", c, t64, imm64, recv + 1, exp);
        end
        if (stalled) begin
          checks++;
          if (imm64 !== hold_imm || t64 !== hold_tag) begin
            failures++;
            $display("FAIL bp_stable c%0d: imm %h tag %0d want imm %h tag %0d", c, imm64, t64, hold_imm, hold_tag);
          end
        end
      end
      if (!rdy32) low_seen++;
      stalled = (held > 0) && !out_ready;
      hold_imm = imm64;
      hold_tag = t64;
      if (in_valid && exp_rdy) sent++;
      if (held > 0 && out_ready) recv++;
    end
    in_valid = 1'b0;
    checks++;
    if (recv != 6 || sent != 6) begin
      failures++;
      $display("FAIL bp_count: sent %0d received %0d want 6/6", sent, recv);
    end
    checks++;
    if (low_seen != 3) begin
      failures++;
      $display("FAIL bp_ready_low_cycles: got %0d want 3", low_seen);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    @(negedge clock);
    inst = 32'h00100093;
    sel = 3'd1;
    tag = 5'd1;
    in_valid = 1'b1;
    @(negedge clock);
    tag = 5'd2;
    @(negedge clock);
    io_flush = 1'b1;
    tag = 5'd31;
    #1;
    checks++;
    if (rdy32 !== 1'b0 || rdy64 !== 1'b0 || ov64 !== 1'b1 || t64 !== 5'd1) begin
      failures++;
      $display("FAIL flush_full_pre: ready %b/%b valid %b tag %0d want 0/0 1 1", rdy32, rdy64, ov64, t64);
    end
    @(negedge clock);
    io_flush = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (ov32 !== 1'b0 || ov64 !== 1'b0 || rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
      failures++;
      $display("FAIL flush_full_post: valid %b/%b ready %b/%b want 0 and 1", ov32, ov64, rdy32, rdy64);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      checks++;
      if (ov32 !== 1'b0 || ov64 !== 1'b0) begin
        failures++;
        $display("FAIL flush_leak c%0d: valid %b/%b tag %0d want 0", c, ov32, ov64, t64);
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    tag = 5'd4;
    @(negedge clock);
    io_flush = 1'b1;
    tag = 5'd5;
    #1;
    checks++;
    if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin
      failures++;
      $display("FAIL flush_one_ready: got %b/%b want 0", rdy32, rdy64);
    end
    @(negedge clock);
    io_flush = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (ov32 !== 1'b0 || ov64 !== 1'b0) begin
      failures++;
      $display("FAIL flush_one_post: valid %b/%b tag %0d want 0", ov32, ov64, t64);
    end
  endtask

  task automatic test_random(input int n);
    ent_t q[$];
    ent_t e;
    logic exp_rdy;
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 99) < 2);
      io_flush = ($urandom_range(0, 99) < 5);
      in_valid = ($urandom_range(0, 99) < 70);
      inst = $urandom;
      sel = 3'($urandom_range(0, 7));
      tag = TAG_W'($urandom);
      out_ready = ($urandom_range(0, 99) < 60);
      #1;
      exp_rdy = !reset && !io_flush && (q.size() < 2);
      checks++;
      if (rdy32 !== exp_rdy || rdy64 !== exp_rdy) begin
        failures++;
        $display("FAIL rand_in_ready c%0d: got %b/%b want %b", c, rdy32, rdy64, exp_rdy);
      end
      checks++;
      if (ov32 !== (q.size() > 0) || ov64 !== (q.size() > 0)) begin
        failures++;
        $display("FAIL rand_out_valid c%0d: got %b/%b want %b", c, ov32, ov64, q.size() > 0);
      end
      if (q.size() > 0) begin
        checks++;
        if (imm64 !== q[0].imm || imm32 !== q[0].imm[31:0] || t32 !== q[0].tag || t64 !== q[0].tag) begin
          failures++;
          $display("FAIL rand_data c%0d: imm %h/%h tag %0d/%0d want %h tag %0d", c, imm32, imm64, t32, t64, q[0].imm, q[0].tag);
        end
`ifdef IMM_GEN_PIPE_ERR_EN
        checks++;
        if (e32 !== q[0].err || e64 !== q[0].err) begin
          failures++;
          $display("FAIL rand_err c%0d: got %b/%b want %b", c, e32, e64, q[0].err);
        end
`endif
      end
      if (reset || io_flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && exp_rdy) begin
          e.imm = ref_imm(inst, sel);
          e.tag = tag;
          e.err = ref_err(sel);
          q.push_back(e);
        end
      end
    end
    @(negedge clock);
    reset = 1'b0;
    io_flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    clear_pipe();
    test_reserved();
    clear_pipe();
    test_backpressure();
    clear_pipe();
    test_flush();
    clear_pipe();
    test_random(600);
    clear_pipe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
